light_phase_timer: RTL
======================

# light_phase_timer

Phase-duration timer that drives the `timer_done` input of the traffic-light controller. It decodes the controller's current `ns_light`/`ew_light` outputs into a phase (green, yellow, all-red) and times that phase with a per-phase tick count. It then issues a single-cycle `timer_done` pulse so the controller advances. It also flags illegal light combinations and never releases the controller from one.

## Interface
- `GREEN_TICKS`, 30, green phase duration in ticks (≥1; 0 treated as 1)
- `YELLOW_TICKS`, 4, yellow phase duration in ticks (≥1; 0 treated as 1)
- `ALLRED_TICKS`, 2, all-red phase duration in ticks (≥1; 0 treated as 1)
- `TICK_DIV`, 1, clock cycles per tick (≥1)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  tick enable; low freezes prescaler and counter
- `ns_light`  in  3  one-hot light, RED=001 YELLOW=010 GREEN=100
- `ew_light`  in  3  same encoding
- `timer_done`  out  1  registered, one-cycle pulse at phase expiry
- `busy`  out  1  registered, high while a phase is being timed
- `fault`  out  1  registered, high while inputs are illegal

## Operation
- Combinational phase decode:
  - PH_GREEN: one side GREEN, other RED.
  - PH_YELLOW: one side YELLOW, other RED.
  - PH_ALLRED: both RED.
  - PH_ILLEGAL: anything else, including both green, non-one-hot values, and 000.
- Registered `phase_q` holds the last decoded phase. A change is detected when decoded ≠ `phase_q`.
- FSM states:
  - S_IDLE: reset state, `phase_q` = PH_NONE.
  - S_COUNT
  - S_EXPIRED
  - S_FAULT
- Change to a legal phase, from any state:
  - `phase_q` ← phase; `cnt` ← DUR(phase); prescaler ← 0; state ← S_COUNT; `busy` ← 1; `fault` ← 0.
  - The load ignores `en`.
- Change to PH_ILLEGAL: state ← S_FAULT; `fault` ← 1; `busy` ← 0; no pulse issued. The block leaves S_FAULT only on a change to a legal phase, which reloads.
- Prescaler: counts 0..TICK_DIV−1 while `en` is high. `tick` = `en` && prescaler==TICK_DIV−1.
- In S_COUNT, on each tick `cnt` decrements. If `cnt`==1 at the tick:
  - `timer_done` ← 1 for one cycle
  - state ← S_EXPIRED
  - `busy` ← 0
- S_EXPIRED: no further pulses until the phase changes.
- Counter width is $clog2(max(DUR)+1). No wrap: `cnt` never goes below 1 in S_COUNT.

## Timing
- Reset values: `timer_done`=0, `busy`=0, `fault`=0, state S_IDLE, `cnt`=0, prescaler=0.
- Cycle 0 is the first cycle a new legal phase is visible on the inputs:
  - The load happens at the end of cycle 0; `busy`=1 from cycle 1.
  - With `en` held high, ticks occur at cycles k·TICK_DIV for k≥1.
  - `timer_done` is high in cycle DUR·TICK_DIV+1 only.
- Controller closed loop: the lights change at cycle DUR·TICK_DIV+2, so each phase lasts DUR·TICK_DIV+2 cycles.
- `en` low stretches expiry by exactly the number of cycles it is low during S_COUNT.
- Simultaneous phase change and expiry condition: the change wins. The counter reloads and no pulse is issued.
- Phase change mid-count: the count is aborted and reloaded, and no pulse is issued for the aborted phase.
- `rst` mid-operation: all state clears at that edge. A `timer_done` pending for the next cycle is suppressed.

## Structure
- Shared package `traffic_pkg` holds:
  - the RED/YELLOW/GREEN localparams, which the controller also imports
  - `phase_t` enum (PH_NONE, PH_GREEN, PH_YELLOW, PH_ALLRED, PH_ILLEGAL)
  - the timer state enum
- Sub-module `tick_prescaler` takes `clk`, `rst`, `en`, `clr` and produces `tick`, parameterised by TICK_DIV.
- The FSM and down-counter stay in this module.

## Test plan
- Reset, then NS=100/EW=001 held with GREEN_TICKS=3, TICK_DIV=1, `en`=1 -> `busy`=1 cycles 1–3; `timer_done`=1 in cycle 4 only; no further pulse while held.
- Closed loop with the controller, YELLOW=2, ALLRED=1, GREEN=3, TICK_DIV=2 -> sequence ALLRED 4 cycles, EW GREEN 8, EW YELLOW 6, ALLRED 4, NS GREEN 8, with exactly one pulse per phase.
- `en` low for 5 cycles mid-green (GREEN=3, DIV=1) -> `timer_done` moves from cycle 4 to cycle 9.
- Yellow→all-red change applied in the same cycle the yellow expiry is due -> no pulse; all-red reload; pulse after ALLRED_TICKS.
- NS=100/EW=100 -> `fault`=1 next cycle, `busy`=0, no pulse; then NS=001/EW=001 -> `fault`=0, and a pulse ALLRED_TICKS·TICK_DIV+1 cycles later.
- `rst` asserted in the cycle before a due pulse -> `timer_done` stays 0 and state returns to S_IDLE; after `rst` deasserts, the still-held legal phase reloads and expiry is retimed from scratch.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: light encodings, phase and timer-state
// enums, and the light-pair to phase decoder.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b100;

    typedef enum logic [2:0] {
        PH_NONE,
        PH_GREEN,
        PH_YELLOW,
        PH_ALLRED,
        PH_ILLEGAL
    } phase_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_EXPIRED,
        S_FAULT
    } timer_state_t;

    function automatic phase_t decode_phase(
        input logic [2:0] ns,
        input logic [2:0] ew
    );
        phase_t p;
        p = PH_ILLEGAL;
        if ((ns == GREEN && ew == RED) || (ns == RED && ew == GREEN))
            p = PH_GREEN;
        else if ((ns == YELLOW && ew == RED) || (ns == RED && ew == YELLOW))
            p = PH_YELLOW;
        else if (ns == RED && ew == RED)
            p = PH_ALLRED;
        return p;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles into ticks; one tick every TICK_DIV
// enabled cycles, restartable from zero by clr.
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV = (TICK_DIV < 1) ? 1 : TICK_DIV;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;

    assign tick = en && (pre == LAST);

    always_ff @(posedge clk) begin
        if (rst)
            pre <= '0;
        else if (clr)
            pre <= '0;
        else if (en)
            pre <= tick ? '0 : pre + 1'b1;
    end

endmodule

// File: rtl/light_phase_timer.sv
// Times the current traffic-light phase and pulses timer_done once at
// expiry; flags illegal light combinations.
module light_phase_timer
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 30,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int TICK_DIV     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] ns_light,
    input  logic [2:0] ew_light,
    output logic       timer_done,
    output logic       busy,
    output logic       fault
);

    localparam int G_D = (GREEN_TICKS  < 1) ? 1 : GREEN_TICKS;
    localparam int Y_D = (YELLOW_TICKS < 1) ? 1 : YELLOW_TICKS;
    localparam int A_D = (ALLRED_TICKS < 1) ? 1 : ALLRED_TICKS;
    localparam int M_GY  = (G_D > Y_D) ? G_D : Y_D;
    localparam int MAX_D = (M_GY > A_D) ? M_GY : A_D;
    localparam int CW    = $clog2(MAX_D + 1);

    phase_t          phase_d;
    phase_t          phase_q;
    timer_state_t    state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   load_val;
    logic            change;
    logic            load;
    logic            tick;

    assign phase_d = decode_phase(ns_light, ew_light);
    assign change  = (phase_d != phase_q);
    assign load    = change && (phase_d != PH_ILLEGAL);

    always_comb begin
        load_val = CW'(A_D);
        case (phase_d)
            PH_GREEN:  load_val = CW'(G_D);
            PH_YELLOW: load_val = CW'(Y_D);
            default:   load_val = CW'(A_D);
        endcase
    end

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    // A phase change always takes priority over an expiry due the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            phase_q    <= PH_NONE;
            cnt        <= '0;
            timer_done <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            timer_done <= 1'b0;
            phase_q    <= phase_d;
            if (change) begin
                if (phase_d == PH_ILLEGAL) begin
                    state <= S_FAULT;
                    fault <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    state <= S_COUNT;
                    cnt   <= load_val;
                    busy  <= 1'b1;
                    fault <= 1'b0;
                end
            end else if (state == S_COUNT && tick) begin
                if (cnt == CW'(1)) begin
                    timer_done <= 1'b1;
                    state      <= S_EXPIRED;
                    busy       <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule
